ps2_scan_fifo: RTL
==================

PS2_SCAN_FIFO -- requirements
Module: ps2_scan_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving FIFO entries; legal values are powers of two from 4 to 256.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port rx_scan_ready, input, 1 bit: keyboard receiver holds a scan code.
REQ-005 SHALL have port rx_scan_code, input, 8 bits: the scan code, valid while rx_scan_ready=1.
REQ-006 SHALL have port rx_released, input, 1 bit: break (F0-prefixed) flag, valid with rx_scan_code.
REQ-007 SHALL have port rx_scan_read, output, 1 bit: one-cycle acknowledge to the keyboard receiver.
REQ-008 SHALL have port rd_en, input, 1 bit: pop request from the bus side.
REQ-009 SHALL have port rd_data, output, 9 bits: head entry, {released, code}.
REQ-010 SHALL have port empty, output, 1 bit; port full, output, 1 bit.
REQ-011 SHALL have port count, output, log2(DEPTH)+1 bits: number of occupied entries.
REQ-012 SHALL have port overflow, output, 1 bit (sticky), and port clr_overflow, input, 1 bit.

Function
REQ-013 The capture FSM SHALL have the states IDLE, ACK and WAIT.
REQ-014 In IDLE with rx_scan_ready=1, the block SHALL latch {rx_released, rx_scan_code}, request a push, and go to ACK.
REQ-015 In ACK, rx_scan_read SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-016 In WAIT, the FSM SHALL stay until rx_scan_ready=0, then return to IDLE; at most one push per rx_scan_ready assertion.
REQ-017 A push SHALL write the latched entry at the tail in the cycle of the IDLE->ACK transition; the entry SHALL be visible on rd_data / count one cycle later.
REQ-018 Reads are first-word fall-through: rd_data SHALL show the head whenever empty=0; rd_en=1 with empty=0 SHALL pop the head at the clock edge.
REQ-019 rd_en while empty=1 SHALL be ignored, with no state change; rd_data in that case is don't-care.
REQ-020 Push and pop in the same cycle SHALL both occur and leave count unchanged, including when full=1.
REQ-021 Push while full=1 without a same-cycle pop SHALL drop the entry, set overflow, and still perform ACK so the receiver is drained.
REQ-022 If overflow-set and clr_overflow coincide, set SHALL win.
REQ-023 Pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-024 full SHALL equal (count==DEPTH); empty SHALL equal (count==0); both are registered or derived from registered count.

Reset
REQ-025 rstn=0 SHALL asynchronously force: FSM=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, rx_scan_read=0.
REQ-026 Storage contents SHALL NOT be reset.
REQ-027 Reset mid-handshake (ACK or WAIT) SHALL abandon the transfer; after release, a still-asserted rx_scan_ready SHALL be captured as new.

Configuration
REQ-028 When the macro PS2_SCAN_FIFO_DEDUP_EN is defined, a make code (released=0) equal to the last accepted entry's code, where that entry was also a make, SHALL be discarded (typematic repeat filter).
REQ-029 A discarded code SHALL still be acknowledged, and SHALL NOT set overflow.
REQ-030 The last-accepted record SHALL be cleared by reset, and any break code SHALL re-arm acceptance.
REQ-031 When the macro is undefined, every code SHALL be pushed and no filter logic SHALL exist.

Structure
REQ-032 Package ps2_pkg SHALL hold the typedef ps2_entry_t (packed: released, code[7:0]) and the FSM state enum ps2_cap_state_e.
REQ-033 Storage and pointers SHALL live in sub-module ps2_fifo_mem (synchronous write, combinational read).
REQ-034 The FSM, dedup logic and flags SHALL live in the top level.

Verification
REQ-035 After reset, one code 0x1C (released=0) SHALL give: rx_scan_read high for exactly 1 cycle; next cycle count=1, rd_data=0x01C, empty=0.
REQ-036 DEPTH=16, 17 codes 0x00..0x10 with no reads SHALL give: full=1, overflow=1; 16 pops SHALL return 0x00..0x0F in order; empty=1 after the last pop.
REQ-037 At full, a push coinciding with rd_en SHALL keep count=16 with no overflow; the new code SHALL appear as the last entry.
REQ-038 With rx_scan_ready held 10 cycles, exactly one push and one rx_scan_read pulse SHALL occur.
REQ-039 With DEDUP_EN, the sequence 0x1C, 0x1C, 0x1C, break 0x1C, 0x1C SHALL queue 0x01C, 0x11C, 0x01C; without DEDUP_EN it SHALL queue all 5 entries.
REQ-040 rstn=0 asserted during WAIT with count=3 SHALL immediately give count=0, empty=1, rx_scan_read=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 scan-code capture FIFO.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ps2_pkg;

    // One queued key event: break flag above the 8-bit scan code.
    typedef struct packed {
        logic       released;
        logic [7:0] code;
    } ps2_entry_t;

    // Receiver handshake states: wait for a code, acknowledge it, wait for the strobe to drop.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } ps2_cap_state_e;

endpackage

// File: rtl/ps2_fifo_mem.sv
// Circular storage with head/tail pointers for the scan-code FIFO.
// Latency: write lands at the clock edge; head is read combinationally (fall-through).
// Backpressure: none here; the caller must only write when there is room and only pop when non-empty.
module ps2_fifo_mem
    import ps2_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_en,
    input  ps2_entry_t wr_data,
    input  logic       rd_en,
    output ps2_entry_t rd_data
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    ps2_entry_t    mem [DEPTH];

    // Pointers advance by one and wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ps2_scan_fifo.sv
// Captures PS/2 scan codes from the keyboard receiver into a FWFT FIFO; optional typematic
// filter under PS2_SCAN_FIFO_DEDUP_EN. Latency: code is on rd_data/count one cycle after capture.
// Backpressure: receiver is always acknowledged; a push into a full FIFO with no pop is dropped and flags overflow.
module ps2_scan_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rx_scan_ready,
    input  logic [7:0]    rx_scan_code,
    input  logic          rx_released,
    output logic          rx_scan_read,
    input  logic          rd_en,
    output logic [8:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow,
    input  logic          clr_overflow
);

    ps2_cap_state_e state;
    ps2_entry_t     cap_entry;
    ps2_entry_t     head_entry;
    logic           capture;
    logic           discard;
    logic           accept;
    logic           pop;
    logic           wr_en;
    logic           ovf_set;

    assign cap_entry = {rx_released, rx_scan_code};

    // A new code is taken only from IDLE, so one receiver strobe yields at most one push.
    assign capture = (state == IDLE) && rx_scan_ready;
    assign pop     = rd_en && !empty;
    assign accept  = capture && !discard;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign wr_en   = accept && (!full || pop);
    assign ovf_set = accept && full && !pop;

`ifdef PS2_SCAN_FIFO_DEDUP_EN
    logic       last_make_vld;
    logic [7:0] last_code;

    // Repeated make of the last accepted make code is typematic repeat and is dropped silently.
    assign discard = last_make_vld && !rx_released && (rx_scan_code == last_code);

    // Track the last accepted make; any break re-arms acceptance of the same key.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_make_vld <= 1'b0;
            last_code     <= '0;
        end else if (capture) begin
            if (rx_released) begin
                last_make_vld <= 1'b0;
            end else if (wr_en) begin
                last_make_vld <= 1'b1;
                last_code     <= rx_scan_code;
            end
        end
    end
`else
    assign discard = 1'b0;
`endif

    // Receiver handshake; rx_scan_read is registered and high only while in ACK.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            rx_scan_read <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_scan_ready) begin
                        state        <= ACK;
                        rx_scan_read <= 1'b1;
                    end
                end
                ACK: begin
                    state        <= WAIT;
                    rx_scan_read <= 1'b0;
                end
                WAIT: begin
                    rx_scan_read <= 1'b0;
                    if (!rx_scan_ready) state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    rx_scan_read <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else begin
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rd_data = head_entry;

    ps2_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_data (cap_entry),
        .rd_en   (pop),
        .rd_data (head_entry)
    );

endmodule
